// File: rtl/frame_flip_responder.sv
// Blitter-side consumer of the page-flip handshake: waits for vertical blank, swaps the
// front/back frame buffers, optionally clears the new back buffer, then acknowledges.
module frame_flip_responder #(
  parameter int                ADDR_W      = 19,
  parameter int                DATA_W      = 16,
  parameter int                CLEAR_WORDS = 307200,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = '0,
  parameter bit                CLEAR_EN    = 1'b1,
  parameter int                ACK_CYCLES  = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Status,
  input  logic              VBlank,
  input  logic              Clr_Gnt,
  output logic              Flip_Blitter,
  output logic              Front_Sel,
  output logic              Clr_Buf,
  output logic [ADDR_W-1:0] Clr_Addr,
  output logic [DATA_W-1:0] Clr_Data,
  output logic              Clr_WE,
  output logic              Busy
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_VB  = 3'd1;
  localparam logic [2:0] ST_SWAP     = 3'd2;
  localparam logic [2:0] ST_CLEAR    = 3'd3;
  localparam logic [2:0] ST_ACK      = 3'd4;
  localparam logic [2:0] ST_WAIT_LOW = 3'd5;

  localparam int                ACK_W     = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CLEAR_WORDS - 1);
  localparam logic [ACK_W-1:0]  LAST_ACK  = ACK_W'(ACK_CYCLES - 1);

  logic [2:0]        state_q,   state_d;
  logic              front_q,   front_d;
  logic [ADDR_W-1:0] cnt_q,     cnt_d;
  logic [ACK_W-1:0]  ack_cnt_q, ack_cnt_d;
  logic              vb_q,      vb_d;
  logic              vb_rise;

  // Edge against the previous sample only; vb_q resets high so a blank already in
  // progress when reset releases is not mistaken for a fresh edge.
  assign vb_rise = VBlank & ~vb_q;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    front_d   = front_q;
    cnt_d     = cnt_q;
    ack_cnt_d = ack_cnt_q;
    vb_d      = VBlank;

    case (state_q)
      ST_IDLE: begin
        if (Status) state_d = ST_WAIT_VB;
      end

      ST_WAIT_VB: begin
        if (vb_rise) state_d = ST_SWAP;
      end

      ST_SWAP: begin
        front_d   = ~front_q;
        cnt_d     = '0;
        ack_cnt_d = '0;
        state_d   = CLEAR_EN ? ST_CLEAR : ST_ACK;
      end

      ST_CLEAR: begin
        // Without a grant the address is simply held and the write stays requested.
        if (Clr_Gnt) begin
          if (cnt_q == LAST_ADDR) begin
            cnt_d   = '0;
            state_d = ST_ACK;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end

      ST_ACK: begin
        if (ack_cnt_q == LAST_ACK) begin
          ack_cnt_d = '0;
          state_d   = ST_WAIT_LOW;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
      end

      ST_WAIT_LOW: begin
        // Holding here until the flag drops guarantees one flip per request.
        if (!Status) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      front_q   <= 1'b0;
      cnt_q     <= '0;
      ack_cnt_q <= '0;
      vb_q      <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop updates from pre-edge values.
      state_q   <= state_d;
      front_q   <= front_d;
      cnt_q     <= cnt_d;
      ack_cnt_q <= ack_cnt_d;
      vb_q      <= vb_d;
    end
  end

  assign Front_Sel    = front_q;
  assign Clr_Buf      = ~front_q;
  assign Clr_Addr     = cnt_q;
  assign Clr_Data     = CLEAR_COLOR;
  assign Clr_WE       = (state_q == ST_CLEAR);
  assign Flip_Blitter = (state_q == ST_ACK);
  assign Busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_frame_flip_responder.sv
// Self-checking bench for frame_flip_responder: directed handshake scenarios followed by
// randomized Status/VBlank/grant/reset traffic, all checked against a work-queue model.
module tb_frame_flip_responder;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 16;
  localparam int CW     = 8;
  localparam int ACKC   = 2;

  logic              Clk     = 1'b0;
  logic              Reset   = 1'b1;
  logic              Status  = 1'b0;
  logic              VBlank  = 1'b0;
  logic              Clr_Gnt = 1'b0;
  logic              Flip_Blitter, Front_Sel, Clr_Buf, Clr_WE, Busy;
  logic [ADDR_W-1:0] Clr_Addr;
  logic [DATA_W-1:0] Clr_Data;

  frame_flip_responder #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .CLEAR_WORDS(CW),
    .CLEAR_COLOR(16'h0000),
    .CLEAR_EN   (1'b1),
    .ACK_CYCLES (ACKC)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Status      (Status),
    .VBlank      (VBlank),
    .Clr_Gnt     (Clr_Gnt),
    .Flip_Blitter(Flip_Blitter),
    .Front_Sel   (Front_Sel),
    .Clr_Buf     (Clr_Buf),
    .Clr_Addr    (Clr_Addr),
    .Clr_Data    (Clr_Data),
    .Clr_WE      (Clr_WE),
    .Busy        (Busy)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: outstanding work of the current request, expressed as counts.
  bit m_armed      = 1'b0;  // request taken, waiting for a blank edge
  bit m_swapping   = 1'b0;  // swap cycle pending
  int m_words_left = 0;     // clear writes still owed
  int m_ack_left   = 0;     // acknowledge cycles still owed
  bit m_retired    = 1'b0;  // acknowledged, waiting for the flag to drop
  bit m_front      = 1'b0;
  bit m_vb_prev    = 1'b1;

  // Observations of the DUT, checked against constants by the directed tests.
  int          obs_addrs[$];
  int          obs_flips, obs_busy_seen, obs_front_changes, obs_hold_bad, obs_bad_data;
  logic        obs_front_prev = 1'b0;
  logic        obs_prev_we    = 1'b0;
  logic        obs_prev_gnt   = 1'b0;
  logic [31:0] obs_prev_addr  = '0;

  task automatic obs_clear();
    obs_addrs.delete();
    obs_flips         = 0;
    obs_busy_seen     = 0;
    obs_front_changes = 0;
    obs_hold_bad      = 0;
    obs_bad_data      = 0;
    obs_front_prev    = Front_Sel;
  endtask

  // One clock: compare outputs with the model, then drive the next inputs and advance.
  task automatic step(input bit rst, input bit st, input bit vb, input bit gnt);
    bit exp_busy, exp_we, exp_flip, vb_rise;
    @(negedge Clk);
    exp_busy = m_armed || m_swapping || (m_words_left > 0) || (m_ack_left > 0) || m_retired;
    exp_we   = !m_armed && !m_swapping && (m_words_left > 0);
    exp_flip = !m_armed && !m_swapping && (m_words_left == 0) && (m_ack_left > 0);
    check("busy", Busy, exp_busy);
    check("clr_we", Clr_WE, exp_we);
    check("flip", Flip_Blitter, exp_flip);
    check("front_sel", Front_Sel, m_front);
    check("clr_buf", Clr_Buf, !m_front);
    if (exp_we) check("clr_data", Clr_Data, 0);
    if (exp_we && gnt) check("wr_addr", Clr_Addr, CW - m_words_left);

    if (Flip_Blitter) obs_flips++;
    if (Busy) obs_busy_seen++;
    if (Front_Sel !== obs_front_prev) obs_front_changes++;
    obs_front_prev = Front_Sel;
    if (Clr_WE) begin
      if (obs_prev_we && !obs_prev_gnt && (32'(Clr_Addr) !== obs_prev_addr)) obs_hold_bad++;
      if (Clr_Data !== '0) obs_bad_data++;
      if (gnt) obs_addrs.push_back(int'(Clr_Addr));
    end
    obs_prev_we   = Clr_WE;
    obs_prev_gnt  = gnt;
    obs_prev_addr = 32'(Clr_Addr);

    Reset   = rst;
    Status  = st;
    VBlank  = vb;
    Clr_Gnt = gnt;

    if (rst) begin
      m_armed = 0; m_swapping = 0; m_words_left = 0; m_ack_left = 0;
      m_retired = 0; m_front = 0; m_vb_prev = 1;
    end else begin
      vb_rise   = vb && !m_vb_prev;
      m_vb_prev = vb;
      if (m_armed) begin
        if (vb_rise) begin m_armed = 0; m_swapping = 1; end
      end else if (m_swapping) begin
        m_swapping   = 0;
        m_front      = !m_front;
        m_words_left = CW;
        m_ack_left   = ACKC;
      end else if (m_words_left > 0) begin
        if (gnt) m_words_left--;
      end else if (m_ack_left > 0) begin
        m_ack_left--;
        if (m_ack_left == 0) m_retired = 1;
      end else if (m_retired) begin
        if (!st) m_retired = 0;
      end else if (st) begin
        m_armed = 1;
      end
    end
  endtask

  // Raise a request, produce one clean blank edge, run until the acknowledge is over.
  // gmode 0: grant always; gmode 1: grant pattern 1,0,0,1,...
  task automatic do_flip(input int gmode);
    int  k;
    bit  g;
    k = 0;
    for (int i = 0; i < 70; i++) begin
      g = (gmode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
      if (i >= 3) k++;
      step(0, 1, (i >= 3 && i < 7), g);
      if (i > 8 && Busy && !Flip_Blitter && obs_flips > 0) break;
    end
  endtask

  task automatic check_clear(input string tag);
    check({tag, "_writes"}, obs_addrs.size(), CW);
    for (int i = 0; i < CW && i < obs_addrs.size(); i++) check({tag, "_addr"}, obs_addrs[i], i);
    check({tag, "_data"}, obs_bad_data, 0);
    check({tag, "_ack_len"}, obs_flips, ACKC);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit          st_r, vb_level;
    int          vb_left;
    logic        front_before;

    // Reset state, then a long idle stretch.
    repeat (3) step(1, 0, 0, 0);
    check("rst_busy", Busy, 0);
    check("rst_front", Front_Sel, 0);
    check("rst_we", Clr_WE, 0);
    check("rst_flip", Flip_Blitter, 0);
    check("rst_addr", Clr_Addr, 0);
    obs_clear();
    repeat (100) step(0, 0, 0, 0);
    check("idle_busy_seen", obs_busy_seen, 0);
    check("idle_front_changes", obs_front_changes, 0);

    // Basic flip with continuous grant.
    check("pre_front", Front_Sel, 0);
    check("pre_clr_buf", Clr_Buf, 1);
    obs_clear();
    do_flip(0);
    check_clear("flip1");
    check("flip1_front", Front_Sel, 1);
    check("flip1_clr_buf", Clr_Buf, 0);
    repeat (3) step(0, 0, 0, 1);
    check("flip1_idle", Busy, 0);

    // Gappy grant: address must hold across gaps.
    obs_clear();
    do_flip(1);
    check_clear("gaps");
    check("gaps_hold", obs_hold_bad, 0);
    check("gaps_front", Front_Sel, 0);
    repeat (2) step(0, 0, 0, 1);

    // Request raised while VBlank already high: no swap until the next edge.
    front_before = Front_Sel;
    obs_clear();
    repeat (3) step(0, 0, 0, 1);
    repeat (2) step(0, 0, 1, 1);
    repeat (5) step(0, 1, 1, 1);
    check("late_front_hold", Front_Sel, front_before);
    check("late_no_writes", obs_addrs.size(), 0);
    check("late_busy", Busy, 1);
    repeat (3) step(0, 1, 0, 1);
    check("late_front_hold2", Front_Sel, front_before);
    repeat (3) step(0, 1, 1, 1);
    repeat (20) step(0, 1, 0, 1);
    check("late_front_flip", Front_Sel, !front_before);
    check_clear("late");

    // Status held high after acknowledge: no second flip across three blanks.
    obs_clear();
    repeat (3) begin
      repeat (3) step(0, 1, 0, 1);
      repeat (3) step(0, 1, 1, 1);
    end
    check("hold_front_changes", obs_front_changes, 0);
    check("hold_writes", obs_addrs.size(), 0);
    check("hold_flips", obs_flips, 0);
    check("hold_busy", Busy, 1);
    repeat (2) step(0, 0, 0, 1);
    check("hold_release", Busy, 0);

    // Reset in the middle of a clear, then a fresh request restarts at address 0.
    repeat (3) step(0, 1, 0, 1);
    for (int i = 0; i < 40; i++) begin
      step(0, 1, (i < 3), 1);
      if (Clr_WE && Clr_Addr == 2) break;
    end
    step(1, 0, 0, 1);
    check("mid_rst_addr", Clr_Addr, 3);
    step(0, 0, 0, 1);
    check("mid_rst_we", Clr_WE, 0);
    check("mid_rst_front", Front_Sel, 0);
    check("mid_rst_busy", Busy, 0);
    obs_clear();
    do_flip(0);
    check_clear("restart");
    repeat (2) step(0, 0, 0, 1);

    // Randomized traffic including occasional resets.
    obs_clear();
    st_r     = 1'b0;
    vb_level = 1'b0;
    vb_left  = 10;
    for (int c = 0; c < 2500; c++) begin
      if (vb_left == 0) begin
        vb_level = !vb_level;
        vb_left  = vb_level ? int'($urandom_range(2, 8)) : int'($urandom_range(6, 30));
      end
      vb_left--;
      if ($urandom_range(0, 7) == 0) st_r = !st_r;
      step($urandom_range(0, 599) == 0, st_r, vb_level, $urandom_range(0, 2) != 0);
    end
    check("rand_activity", obs_front_changes > 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
